// File: rtl/lap_watch_pkg.sv
// Shared definitions for the lap stopwatch.
//   state_t    : controller states (IDLE, RUN, STOP, RECALL)
//   UNITS_MAX  : rollover value of a units digit (9)
//   TENS_MAX   : rollover value of a tens digit (5)
//   time_rec_t : 16-bit time record {min_tens, min_units, sec_tens, sec_units}
package watch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP,
    RECALL
  } state_t;

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
  } time_rec_t;

endpackage

// File: rtl/lap_watch_if.sv
// Command and display bundle of the lap stopwatch.
//   start_stop, lap, recall : one-cycle command pulses (master -> slave)
//   sec_units .. min_tens   : displayed time, BCD (slave -> master)
//   running, recall_valid   : status flags
//   lap_count               : number of stored laps
//   leds                    : status bar
interface lap_watch_if #(
  parameter int unsigned LAP_DEPTH  = 4,
  parameter int unsigned LED_NUMBER = 10
) ();

  logic                           start_stop;
  logic                           lap;
  logic                           recall;
  logic [3:0]                     sec_units;
  logic [3:0]                     sec_tens;
  logic [3:0]                     min_units;
  logic [3:0]                     min_tens;
  logic                           running;
  logic                           recall_valid;
  logic [$clog2(LAP_DEPTH):0]     lap_count;
  logic [LED_NUMBER-1:0]          leds;

  modport master (
    output start_stop, lap, recall,
    input  sec_units, sec_tens, min_units, min_tens,
    input  running, recall_valid, lap_count, leds
  );

  modport slave (
    input  start_stop, lap, recall,
    output sec_units, sec_tens, min_units, min_tens,
    output running, recall_valid, lap_count, leds
  );

endinterface

// File: rtl/lap_watch_bcd_digit.sv
// One BCD digit counter with programmable rollover value.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear
//   en       : advance by one this cycle
//   max_val  : value after which the digit wraps to 0
//   q        : current digit
//   carry    : high when enabled while at max_val (next digit advances)
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] max_val,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = en && (q == max_val);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= (q == max_val) ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/lap_watch.sv
// Lap stopwatch: mm:ss BCD timer with a small lap buffer and recall mode.
//   clk, rst : clock, synchronous active-high reset
//   bus      : lap_watch_if slave port
//              in : start_stop, lap, recall (one-cycle pulses,
//                   priority start_stop > lap > recall)
//              out: BCD time, running, recall_valid, lap_count, leds
// All outputs are registered one cycle behind the internal state.
module lap_watch
  import watch_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 50_000_000,
  parameter int unsigned LAP_DEPTH  = 4,
  parameter int unsigned LED_NUMBER = 10
) (
  input  logic        clk,
  input  logic        rst,
  lap_watch_if.slave  bus
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned IDX_W = $clog2(LAP_DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LAP_DEPTH);

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [CNT_W-1:0]  lap_cnt;
  logic [IDX_W-1:0]  rd_idx;
  time_rec_t         laps [LAP_DEPTH];
  time_rec_t         live;

  logic cmd_ss, cmd_lap, cmd_recall;
  logic tick, clear_all, lap_wr;
  logic c_su, c_st, c_mu, carry_unused;

  // Lower-priority pulses are masked by any higher-priority one.
  assign cmd_ss     = bus.start_stop;
  assign cmd_lap    = bus.lap && !bus.start_stop;
  assign cmd_recall = bus.recall && !bus.lap && !bus.start_stop;

  assign tick      = (state == RUN) && (div == DIV_LAST);
  assign clear_all = !rst && (state == STOP) && cmd_lap;
  assign lap_wr    = !rst && (state == RUN) && cmd_lap && (lap_cnt != CNT_FULL);

  // Controller
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lap_cnt <= '0;
      rd_idx  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_ss) state <= RUN;
        end
        RUN: begin
          if (cmd_ss) state <= STOP;
          else if (lap_wr) lap_cnt <= lap_cnt + 1'b1;
        end
        STOP: begin
          if (cmd_ss) begin
            state <= RUN;
          end else if (cmd_lap) begin
            state   <= IDLE;
            lap_cnt <= '0;
            rd_idx  <= '0;
          end else if (cmd_recall && (lap_cnt != '0)) begin
            state  <= RECALL;
            rd_idx <= '0;
          end
        end
        RECALL: begin
          if (cmd_ss) begin
            state <= STOP;
          end else if (cmd_recall) begin
            rd_idx <= (rd_idx == IDX_W'(lap_cnt - 1'b1)) ? '0 : rd_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Divider only advances in RUN, so a stopped partial second is kept.
  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      div <= '0;
    end else if (state == RUN) begin
      div <= tick ? '0 : div + 1'b1;
    end
  end

  // Lap storage: plain register array, no reset (unreadable while lap_cnt is 0).
  // The write captures the time as it stood before this cycle's tick.
  always_ff @(posedge clk) begin
    if (lap_wr) begin
      laps[lap_cnt[IDX_W-1:0]] <= live;
    end
  end

  // Time chain; the min_tens carry is dropped so 59:59 wraps to 00:00.
  bcd_digit u_sec_units (
    .clk(clk), .rst(rst), .clr(clear_all), .en(tick),
    .max_val(UNITS_MAX), .q(live.sec_units), .carry(c_su)
  );
  bcd_digit u_sec_tens (
    .clk(clk), .rst(rst), .clr(clear_all), .en(c_su),
    .max_val(TENS_MAX), .q(live.sec_tens), .carry(c_st)
  );
  bcd_digit u_min_units (
    .clk(clk), .rst(rst), .clr(clear_all), .en(c_st),
    .max_val(UNITS_MAX), .q(live.min_units), .carry(c_mu)
  );
  bcd_digit u_min_tens (
    .clk(clk), .rst(rst), .clr(clear_all), .en(c_mu),
    .max_val(TENS_MAX), .q(live.min_tens), .carry(carry_unused)
  );

  // Output stage
  time_rec_t             shown;
  logic [LED_NUMBER-1:0] led_next;

  always_comb begin
    shown = (state == RECALL) ? laps[rd_idx] : live;
    led_next = '0;
    for (int unsigned i = 0; i < LAP_DEPTH; i++) begin
      led_next[i] = (i < 32'(lap_cnt));
    end
    led_next[LED_NUMBER-1] = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sec_units    <= '0;
      bus.sec_tens     <= '0;
      bus.min_units    <= '0;
      bus.min_tens     <= '0;
      bus.running      <= 1'b0;
      bus.recall_valid <= 1'b0;
      bus.lap_count    <= '0;
      bus.leds         <= '0;
    end else begin
      bus.sec_units    <= shown.sec_units;
      bus.sec_tens     <= shown.sec_tens;
      bus.min_units    <= shown.min_units;
      bus.min_tens     <= shown.min_tens;
      bus.running      <= (state == RUN);
      bus.recall_valid <= (state == RECALL);
      bus.lap_count    <= lap_cnt;
      bus.leds         <= led_next;
    end
  end

endmodule

// File: doc/lap_watch.md
LAP_WATCH -- requirements
Module: lap_watch

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50_000_000: clk cycles per one-second tick; minimum 2.
REQ-002 SHALL have parameter LAP_DEPTH, default 4: number of lap entries stored; power of two, 2..16.
REQ-003 SHALL have parameter LED_NUMBER, default 10: LED bar width; must be at least LAP_DEPTH+1.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start_stop  input  1  one-cycle command pulse.
REQ-007 SHALL have port lap  input  1  one-cycle command pulse.
REQ-008 SHALL have port recall  input  1  one-cycle command pulse.
REQ-009 SHALL have ports sec_units, sec_tens, min_units, min_tens  output  4 each  displayed time, BCD.
REQ-010 SHALL have port running  output  1  high in RUN.
REQ-011 SHALL have port recall_valid  output  1  high in RECALL; the time outputs then show a stored lap.
REQ-012 SHALL have port lap_count  output  $clog2(LAP_DEPTH)+1  number of stored laps.
REQ-013 SHALL have port leds  output  LED_NUMBER  status bar.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, STOP, RECALL.
REQ-015 Command priority SHALL be start_stop > lap > recall; lower-priority pulses arriving in the same cycle SHALL be dropped.
REQ-016 IDLE: start_stop -> RUN; lap and recall ignored.
REQ-017 RUN: start_stop -> STOP; lap stores the live time; recall ignored.
REQ-018 STOP: start_stop -> RUN; lap clears the time, the divider and all laps, then -> IDLE; recall -> RECALL with read index 0 if lap_count>0, otherwise ignored.
REQ-019 RECALL: recall advances the read index, wrapping from lap_count-1 to 0; start_stop -> STOP; lap ignored.
REQ-020 The divider SHALL count 0..CLK_DIV-1 only in RUN and SHALL issue a tick in the cycle it equals CLK_DIV-1, then wrap to 0.
REQ-021 The divider SHALL hold its value in STOP and RECALL, so a partial second is kept.
REQ-022 On a tick, the time SHALL advance by one second in BCD: sec_units 9->0 carries to sec_tens; sec_tens 5->0 carries to min_units; min_units 9->0 carries to min_tens; 59:59 wraps to 00:00.
REQ-023 A lap SHALL store the time held before any tick in the same cycle, at write pointer lap_count, and SHALL increment lap_count.
REQ-024 A lap SHALL be ignored when lap_count==LAP_DEPTH (buffer full); existing entries SHALL NOT be overwritten.
REQ-025 Time outputs SHALL be registered with 1-cycle latency from a state or counter update.
REQ-026 In RECALL, the time outputs SHALL show entry[read index]; in all other states they SHALL show the live time.
REQ-027 leds[lap_count-1:0] SHALL be high as a thermometer, leds[LED_NUMBER-1] SHALL equal running, and all other bits SHALL be 0.

Reset
REQ-028 rst SHALL set: state IDLE; divider 0; time 00:00; lap_count 0; read index 0; all outputs 0.
REQ-029 rst SHALL override any command in the same cycle, including mid-count and in RECALL.
REQ-030 Stored lap contents need no reset; they SHALL be unreadable until rewritten, because lap_count is 0.

Structure
REQ-031 The FSM state enum, BCD limits (9, 5) and the 16-bit time-record layout {min_tens,min_units,sec_tens,sec_units} SHALL be defined in the shared package watch_pkg.
REQ-032 The block SHALL contain one sub-module, bcd_digit (a 4-bit counter with programmable max, enable in, carry out), instantiated four times.
REQ-033 Lap storage SHALL be a register array of LAP_DEPTH x 16 bits with no RAM macro.

Verification (CLK_DIV=4, LAP_DEPTH=4, LED_NUMBER=10)
REQ-034 rst, then start_stop, then 240 cycles -> time 01:00, running=1, leds=10'b1000000000.
REQ-035 Preload the time to 59:58 and run 8 cycles -> 00:00, and no carry beyond min_tens.
REQ-036 In RUN, 5 laps at the times 00:01..00:05 -> lap_count=4, leds[3:0]=4'hF, and the fifth lap is dropped.
REQ-037 From the state of REQ-036: start_stop, then recall x5 -> outputs 00:01,00:02,00:03,00:04,00:01 with recall_valid=1; then start_stop -> live time with recall_valid=0.
REQ-038 start_stop and lap in the same cycle in RUN -> STOP and no lap stored; lap in STOP -> IDLE, 00:00, lap_count=0.
REQ-039 Stop with the divider at 2, then restart -> the first tick occurs 1 cycle later; rst asserted in RECALL -> all outputs 0 next cycle.
